// File: rtl/vga_timing_gen.sv
// Raster timing generator with a runtime-loadable timing set. Loads are
// validated into a shadow set that is applied only on the last pixel of a frame.
module vga_timing_gen #(
  parameter int   CNT_W         = 11,
  parameter int   H_TOTAL       = 1650,
  parameter int   H_BLANK_START = 1280,
  parameter int   H_BLANK_TIME  = 370,
  parameter int   H_SYNC_START  = 1390,
  parameter int   H_SYNC_TIME   = 40,
  parameter int   V_TOTAL       = 750,
  parameter int   V_BLANK_START = 720,
  parameter int   V_BLANK_TIME  = 30,
  parameter int   V_SYNC_START  = 725,
  parameter int   V_SYNC_TIME   = 5,
  parameter logic HSYNC_POL     = 1'b1,
  parameter logic VSYNC_POL     = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_h_total,
  input  logic [CNT_W-1:0] cfg_h_blank_start,
  input  logic [CNT_W-1:0] cfg_h_blank_time,
  input  logic [CNT_W-1:0] cfg_h_sync_start,
  input  logic [CNT_W-1:0] cfg_h_sync_time,
  input  logic [CNT_W-1:0] cfg_v_total,
  input  logic [CNT_W-1:0] cfg_v_blank_start,
  input  logic [CNT_W-1:0] cfg_v_blank_time,
  input  logic [CNT_W-1:0] cfg_v_sync_start,
  input  logic [CNT_W-1:0] cfg_v_sync_time,
  input  logic             cfg_hpol,
  input  logic             cfg_vpol,
  output logic             cfg_pending,
  output logic             cfg_err,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hblnk,
  output logic             vblnk,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
);

  typedef struct packed {
    logic [CNT_W-1:0] h_total;
    logic [CNT_W-1:0] h_bs;
    logic [CNT_W-1:0] h_bt;
    logic [CNT_W-1:0] h_ss;
    logic [CNT_W-1:0] h_st;
    logic [CNT_W-1:0] v_total;
    logic [CNT_W-1:0] v_bs;
    logic [CNT_W-1:0] v_bt;
    logic [CNT_W-1:0] v_ss;
    logic [CNT_W-1:0] v_st;
    logic             hpol;
    logic             vpol;
  } timing_t;

  localparam timing_t DEFAULT_SET = '{
    h_total: CNT_W'(H_TOTAL),      h_bs: CNT_W'(H_BLANK_START),
    h_bt:    CNT_W'(H_BLANK_TIME), h_ss: CNT_W'(H_SYNC_START),
    h_st:    CNT_W'(H_SYNC_TIME),
    v_total: CNT_W'(V_TOTAL),      v_bs: CNT_W'(V_BLANK_START),
    v_bt:    CNT_W'(V_BLANK_TIME), v_ss: CNT_W'(V_SYNC_START),
    v_st:    CNT_W'(V_SYNC_TIME),
    hpol:    HSYNC_POL,            vpol: VSYNC_POL
  };

  // Window ends are formed one bit wider so start+len cannot wrap.
  function automatic logic in_win(input logic [CNT_W-1:0] v,
                                  input logic [CNT_W-1:0] start,
                                  input logic [CNT_W-1:0] len);
    logic [CNT_W:0] stop;
    stop = {1'b0, start} + {1'b0, len};
    return (v >= start) && ({1'b0, v} < stop);
  endfunction

  function automatic logic axis_ok(input logic [CNT_W-1:0] total,
                                   input logic [CNT_W-1:0] bs,
                                   input logic [CNT_W-1:0] bt,
                                   input logic [CNT_W-1:0] ss,
                                   input logic [CNT_W-1:0] st);
    logic [CNT_W:0] b_end;
    logic [CNT_W:0] s_end;
    b_end = {1'b0, bs} + {1'b0, bt};
    s_end = {1'b0, ss} + {1'b0, st};
    return (total >= CNT_W'(2)) && (bt != '0) && (st != '0) &&
           (b_end <= {1'b0, total}) && (bs <= ss) && (s_end <= b_end);
  endfunction

  timing_t          act_q, act_d;
  timing_t          shd_q, shd_d;
  timing_t          cfg_in;
  logic             pending_q, pending_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             hblnk_q, hblnk_d;
  logic             vblnk_q, vblnk_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             load_ok;
  logic             h_last;
  logic             v_last;
  logic             apply;

  always_comb begin
    cfg_in = '{
      h_total: cfg_h_total, h_bs: cfg_h_blank_start, h_bt: cfg_h_blank_time,
      h_ss: cfg_h_sync_start, h_st: cfg_h_sync_time,
      v_total: cfg_v_total, v_bs: cfg_v_blank_start, v_bt: cfg_v_blank_time,
      v_ss: cfg_v_sync_start, v_st: cfg_v_sync_time,
      hpol: cfg_hpol, vpol: cfg_vpol
    };
    load_ok = axis_ok(cfg_h_total, cfg_h_blank_start, cfg_h_blank_time,
                      cfg_h_sync_start, cfg_h_sync_time) &&
              axis_ok(cfg_v_total, cfg_v_blank_start, cfg_v_blank_time,
                      cfg_v_sync_start, cfg_v_sync_time);

    h_last = (hcount_q == act_q.h_total - CNT_W'(1));
    v_last = (vcount_q == act_q.v_total - CNT_W'(1));
    apply  = en && pending_q && h_last && v_last;

    act_d     = act_q;
    shd_d     = shd_q;
    pending_d = pending_q;
    err_d     = cfg_load && !load_ok;
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;
    hblnk_d   = hblnk_q;
    vblnk_d   = vblnk_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;

    if (en) begin
      if (apply) begin
        act_d     = shd_q;
        pending_d = 1'b0;
      end
      if (h_last) begin
        hcount_d = '0;
        vcount_d = v_last ? '0 : vcount_q + CNT_W'(1);
      end else begin
        hcount_d = hcount_q + CNT_W'(1);
      end
      // Strobes are derived from the next counts and next set so they
      // land in the same register stage as the counters.
      hblnk_d = in_win(hcount_d, act_d.h_bs, act_d.h_bt);
      vblnk_d = in_win(vcount_d, act_d.v_bs, act_d.v_bt);
      hsync_d = in_win(hcount_d, act_d.h_ss, act_d.h_st) ? act_d.hpol : ~act_d.hpol;
      vsync_d = in_win(vcount_d, act_d.v_ss, act_d.v_st) ? act_d.vpol : ~act_d.vpol;
    end

    // A load in the apply cycle lands in the shadow after the copy above.
    if (cfg_load && load_ok) begin
      shd_d     = cfg_in;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q     <= DEFAULT_SET;
      shd_q     <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      hcount_q  <= '0;
      vcount_q  <= '0;
      hblnk_q   <= 1'b0;
      vblnk_q   <= 1'b0;
      hsync_q   <= ~HSYNC_POL;
      vsync_q   <= ~VSYNC_POL;
    end else begin
      act_q     <= act_d;
      shd_q     <= shd_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      hblnk_q   <= hblnk_d;
      vblnk_q   <= vblnk_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  assign cfg_pending = pending_q;
  assign cfg_err     = err_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = en && (hcount_q == '0) && (vcount_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a raster-position reference model predicts every
// output each cycle under directed and randomized timing loads.
module tb_vga_timing_gen;

  localparam int W = 11;

  typedef struct {
    int ht, hbs, hbt, hss, hst;
    int vt, vbs, vbt, vss, vst;
    bit hp, vp;
  } cfg_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         cfg_load = 1'b0;
  cfg_t         drv;
  logic         cfg_pending, cfg_err, hblnk, vblnk, hsync, vsync, frame_start;
  logic [W-1:0] hcount, vcount;
  logic [28:0]  obs;

  int total = 0;
  int bad = 0;

  // Model state: linear pixel position within the frame plus register sets.
  cfg_t m_act, m_shd;
  int   m_pos;
  bit   m_pend, m_err;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CNT_W(W),
    .H_TOTAL(32), .H_BLANK_START(24), .H_BLANK_TIME(8),
    .H_SYNC_START(26), .H_SYNC_TIME(3),
    .V_TOTAL(12), .V_BLANK_START(9), .V_BLANK_TIME(3),
    .V_SYNC_START(10), .V_SYNC_TIME(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load),
    .cfg_h_total(W'(drv.ht)), .cfg_h_blank_start(W'(drv.hbs)),
    .cfg_h_blank_time(W'(drv.hbt)), .cfg_h_sync_start(W'(drv.hss)),
    .cfg_h_sync_time(W'(drv.hst)),
    .cfg_v_total(W'(drv.vt)), .cfg_v_blank_start(W'(drv.vbs)),
    .cfg_v_blank_time(W'(drv.vbt)), .cfg_v_sync_start(W'(drv.vss)),
    .cfg_v_sync_time(W'(drv.vst)),
    .cfg_hpol(drv.hp), .cfg_vpol(drv.vp),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err),
    .hcount(hcount), .vcount(vcount),
    .hblnk(hblnk), .vblnk(vblnk), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start)
  );

  assign obs = {cfg_pending, cfg_err, hcount, vcount, hblnk, vblnk, hsync, vsync, frame_start};

  function automatic cfg_t def_cfg();
    cfg_t c;
    c = '{32, 24, 8, 26, 3, 12, 9, 3, 10, 1, 1'b1, 1'b1};
    return c;
  endfunction

  function automatic cfg_t small_cfg();
    cfg_t c;
    c = '{10, 6, 4, 7, 2, 5, 3, 2, 3, 1, 1'b0, 1'b0};
    return c;
  endfunction

  function automatic bit ax_ok(int t, int bs, int bt, int ss, int st);
    return t >= 2 && bt >= 1 && st >= 1 && bs + bt <= t && bs <= ss && ss + st <= bs + bt;
  endfunction

  function automatic bit cfg_ok(cfg_t c);
    return ax_ok(c.ht, c.hbs, c.hbt, c.hss, c.hst) && ax_ok(c.vt, c.vbs, c.vbt, c.vss, c.vst);
  endfunction

  function automatic cfg_t gen_valid();
    cfg_t c;
    c.ht  = $urandom_range(2, 14);
    c.hbt = $urandom_range(1, c.ht);
    c.hbs = $urandom_range(0, c.ht - c.hbt);
    c.hst = $urandom_range(1, c.hbt);
    c.hss = $urandom_range(c.hbs, c.hbs + c.hbt - c.hst);
    c.vt  = $urandom_range(2, 7);
    c.vbt = $urandom_range(1, c.vt);
    c.vbs = $urandom_range(0, c.vt - c.vbt);
    c.vst = $urandom_range(1, c.vbt);
    c.vss = $urandom_range(c.vbs, c.vbs + c.vbt - c.vst);
    c.hp  = 1'($urandom_range(0, 1));
    c.vp  = 1'($urandom_range(0, 1));
    return c;
  endfunction

  function automatic cfg_t gen_garbage();
    cfg_t c;
    c = gen_valid();
    case ($urandom_range(0, 5))
      0: c.hss = c.hbs + c.hbt;
      1: c.vst = 0;
      2: c.ht = $urandom_range(0, 1);
      3: c.hbs = $urandom_range(2000, 2047);
      4: c.vss = (c.vbs == 0) ? 0 : c.vbs - 1;
      default: begin
        c.ht = $urandom_range(0, 2047); c.hbs = $urandom_range(0, 2047);
        c.hbt = $urandom_range(0, 2047); c.hss = $urandom_range(0, 2047);
        c.hst = $urandom_range(0, 2047);
      end
    endcase
    return c;
  endfunction

  function automatic logic [28:0] expv();
    int  hc, vc;
    logic hb, vb, hs, vs, fs;
    hc = m_pos % m_act.ht;
    vc = m_pos / m_act.ht;
    hb = hc >= m_act.hbs && hc < m_act.hbs + m_act.hbt;
    vb = vc >= m_act.vbs && vc < m_act.vbs + m_act.vbt;
    hs = (hc >= m_act.hss && hc < m_act.hss + m_act.hst) ? m_act.hp : !m_act.hp;
    vs = (vc >= m_act.vss && vc < m_act.vss + m_act.vst) ? m_act.vp : !m_act.vp;
    fs = en && m_pos == 0;
    return {m_pend, m_err, W'(hc), W'(vc), hb, vb, hs, vs, fs};
  endfunction

  task automatic model_reset();
    m_act = def_cfg(); m_pos = 0; m_pend = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit ok, app;
    ok    = cfg_ok(drv);
    app   = en && m_pend && m_pos == m_act.ht * m_act.vt - 1;
    m_err = cfg_load && !ok;
    if (en) begin
      m_pos = (m_pos + 1) % (m_act.ht * m_act.vt);
      if (app) begin m_act = m_shd; m_pend = 0; m_pos = 0; end
    end
    if (cfg_load && ok) begin m_shd = drv; m_pend = 1; end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; cfg_load = 1'b0; drv = def_cfg();
    model_reset();
    tick();
    total++;
    if (obs !== expv()) begin bad++; $display("FAIL reset_vals got=%h want=%h", obs, expv()); end
    total++;
    if (frame_start !== 1'b1) begin bad++; $display("FAIL reset_fs_en1 got=%b want=1", frame_start); end
    en = 1'b0; #1;
    total++;
    if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs_en0 got=%b want=0", frame_start); end
    en = 1'b1;
    tick();
    rst_n = 1'b1; #1;
  endtask

  task automatic test_defaults();
    int per = 0;
    for (int i = 1; i <= 800; i++) begin
      tick();
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL defaults i=%0d got=%h want=%h", i, obs, expv()); end
      if (frame_start && per == 0) per = i;
    end
    total++;
    if (per != 32 * 12) begin bad++; $display("FAIL default_period got=%0d want=%0d", per, 32 * 12); end
  endtask

  task automatic test_small_load();
    int per = 0, hs_low = 0, vs_low = 0, n = 0;
    for (int i = 0; i < 7; i++) tick();
    drv = small_cfg(); cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    while (m_pend && n < 1000) begin
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL small_pend got=%h want=%h", obs, expv()); end
      tick(); n++;
    end
    total++;
    if (n >= 1000) begin bad++; $display("FAIL small_apply_timeout got=%0d want<1000", n); end
    for (int i = 1; i <= 60; i++) begin
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL small_run got=%h want=%h", obs, expv()); end
      if (i <= 50) begin
        if (hsync === 1'b0) hs_low++;
        if (vsync === 1'b0) vs_low++;
      end
      tick();
      if (frame_start && per == 0) per = i;
    end
    total++;
    if (per != 50) begin bad++; $display("FAIL small_period got=%0d want=50", per); end
    total++;
    if (hs_low != 10 || vs_low != 10) begin
      bad++; $display("FAIL small_sync_low got=%0d/%0d want=10/10", hs_low, vs_low);
    end
  endtask

  task automatic test_invalid();
    cfg_t c;
    c = small_cfg(); c.hss = 9; c.hst = 2;
    drv = c; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    total++;
    if (obs !== expv() || cfg_err !== 1'b1) begin bad++; $display("FAIL invalid_err got=%h want=%h", obs, expv()); end
    tick();
    total++;
    if (obs !== expv() || cfg_err !== 1'b0) begin bad++; $display("FAIL invalid_err_clear got=%h want=%h", obs, expv()); end
    c = small_cfg(); c.ht = 2047; c.hbs = 2040; c.hbt = 20; c.hss = 2040; c.hst = 5;
    drv = c; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    total++;
    if (obs !== expv() || cfg_err !== 1'b1) begin bad++; $display("FAIL overflow_err got=%h want=%h", obs, expv()); end
    for (int i = 0; i < 60; i++) begin
      tick();
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL invalid_run got=%h want=%h", obs, expv()); end
    end
  endtask

  task automatic test_two_loads();
    cfg_t a, b;
    int n = 0, per = 0;
    a = gen_valid(); b = gen_valid();
    drv = a; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    tick();
    drv = b; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    while (m_pend && n < 200) begin
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL two_pend got=%h want=%h", obs, expv()); end
      tick(); n++;
    end
    for (int i = 1; i <= b.ht * b.vt + 2; i++) begin
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL two_run got=%h want=%h", obs, expv()); end
      tick();
      if (frame_start && per == 0) per = i;
    end
    total++;
    if (per != b.ht * b.vt) begin bad++; $display("FAIL two_period got=%0d want=%0d", per, b.ht * b.vt); end
  endtask

  task automatic test_apply_cycle_load();
    cfg_t a, b;
    int n = 0, per = 0;
    a = gen_valid(); b = gen_valid();
    drv = a; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    while (!(m_pend && m_pos == m_act.ht * m_act.vt - 1) && n < 200) begin tick(); n++; end
    total++;
    if (n >= 200) begin bad++; $display("FAIL apply_wait_timeout got=%0d want<200", n); end
    drv = b; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    total++;
    if (obs !== expv() || cfg_pending !== 1'b1 || hcount !== '0 || vcount !== '0) begin
      bad++; $display("FAIL apply_cycle_load got=%h want=%h", obs, expv());
    end
    for (int i = 1; i <= a.ht * a.vt; i++) begin
      tick();
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL apply_first got=%h want=%h", obs, expv()); end
    end
    for (int i = 1; i <= b.ht * b.vt + 2; i++) begin
      tick();
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL apply_second got=%h want=%h", obs, expv()); end
      if (frame_start && per == 0) per = i;
    end
    total++;
    if (per != b.ht * b.vt) begin bad++; $display("FAIL apply_second_period got=%0d want=%0d", per, b.ht * b.vt); end
  endtask

  task automatic test_en_hold();
    logic [28:0] snap;
    int n = 0;
    drv = small_cfg(); cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    while ((m_pend || m_pos % m_act.ht != 5) && n < 400) begin tick(); n++; end
    total++;
    if (n >= 400) begin bad++; $display("FAIL en_wait_timeout got=%0d want<400", n); end
    en = 1'b0; #1;
    snap = obs;
    total++;
    if (hcount !== W'(5)) begin bad++; $display("FAIL en_at5 got=%0d want=5", hcount); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs !== snap || obs !== expv()) begin bad++; $display("FAIL en_hold got=%h want=%h", obs, snap); end
    end
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL en_resume got=%h want=%h", obs, expv()); end
    end
  endtask

  task automatic test_reset_mid();
    drv = gen_valid(); cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    tick(); tick();
    total++;
    if (cfg_pending !== 1'b1) begin bad++; $display("FAIL rstmid_pending_before got=%b want=1", cfg_pending); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs !== expv() || hcount !== '0 || vcount !== '0 || cfg_pending !== 1'b0) begin
      bad++; $display("FAIL rstmid_async got=%h want=%h", obs, expv());
    end
    tick();
    rst_n = 1'b1; #1;
    for (int i = 0; i < 400; i++) begin
      tick();
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL rstmid_run got=%h want=%h", obs, expv()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 7) != 0);
      cfg_load = ($urandom_range(0, 39) == 0);
      if (cfg_load) drv = ($urandom_range(0, 1) != 0) ? gen_valid() : gen_garbage();
      tick();
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL random i=%0d got=%h want=%h", i, obs, expv()); end
    end
    en = 1'b1; cfg_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_small_load();
    test_invalid();
    test_two_loads();
    test_apply_cycle_load();
    test_en_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Runtime-reconfigurable VGA/HDMI raster timing generator, the parametrised successor to the fixed 1280x720@60 timing constants. It produces pixel/line counters, blanking and sync strobes for the drawing pipeline. Timing defaults come from parameters, and a new timing set can be loaded at runtime. A loaded set is validated, held in a shadow register and applied only at a frame boundary, so a frame is never torn.

## Interface
Parameters:
- `CNT_W`, 11: width of all counters and timing fields.
- `H_TOTAL`, 1650: pixels per line.
- `H_BLANK_START`, 1280: first blanked pixel.
- `H_BLANK_TIME`, 370: blanked pixels.
- `H_SYNC_START`, 1390: first hsync pixel.
- `H_SYNC_TIME`, 40: hsync pixels.
- `V_TOTAL`, 750: lines per frame.
- `V_BLANK_START`, 720: first blanked line.
- `V_BLANK_TIME`, 30: blanked lines.
- `V_SYNC_START`, 725: first vsync line.
- `V_SYNC_TIME`, 5: vsync lines.
- `HSYNC_POL`, 1: hsync polarity; 1 = active-high.
- `VSYNC_POL`, 1: vsync polarity; 1 = active-high.

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: count enable; when low, all state and outputs hold.
- `cfg_load` in 1: single-cycle request to load the `cfg_*` fields.
- `cfg_h_total`, `cfg_h_blank_start`, `cfg_h_blank_time`, `cfg_h_sync_start`, `cfg_h_sync_time` in CNT_W each: horizontal timing set.
- `cfg_v_total`, `cfg_v_blank_start`, `cfg_v_blank_time`, `cfg_v_sync_start`, `cfg_v_sync_time` in CNT_W each: vertical timing set.
- `cfg_hpol`, `cfg_vpol` in 1 each: sync polarities.
- `cfg_pending` out 1: a shadow set is waiting for the frame boundary.
- `cfg_err` out 1: one-cycle pulse when a `cfg_load` is rejected.
- `hcount`, `vcount` out CNT_W: current pixel and line.
- `hblnk`, `vblnk`, `hsync`, `vsync` out 1: strobes aligned to `hcount`/`vcount`.
- `frame_start` out 1: high while `hcount==0 && vcount==0` and `en` is high.

## Operation
- Register sets:
  - Active set drives counting.
  - Shadow set holds the pending load.
  - Reset loads the parameter values into the active set and clears the shadow.
- Horizontal counter:
  - `hcount` counts 0..h_total-1 on each `en` cycle, then wraps to 0.
- Vertical counter:
  - `vcount` increments on each `hcount` wrap.
  - It counts 0..v_total-1, then wraps to 0.
- Strobes, all registered together with the counters so no output lags:
  - `hblnk` = h_blank_start <= hcount < h_blank_start+h_blank_time.
  - `hsync` active = h_sync_start <= hcount < h_sync_start+h_sync_time, driven at the hpol level; the inactive level is the inverse.
  - `vblnk` and `vsync` follow the same rules on `vcount`, for whole lines.
- Validation of a `cfg_load` (per axis), all rules must hold:
  - total >= 2.
  - blank_time >= 1 and sync_time >= 1.
  - blank_start + blank_time <= total.
  - blank_start <= sync_start.
  - sync_start + sync_time <= blank_start + blank_time.
  - Sums are computed at CNT_W+1 bits, so no overflow aliasing.
- Accepted load:
  - Shadow is written.
  - `cfg_pending` goes high next cycle.
  - A later accepted load while pending overwrites the shadow (latest wins).
- Rejected load:
  - `cfg_err` pulses for one cycle.
  - Shadow and `cfg_pending` are unchanged.
- Apply:
  - Applies on the `en` cycle where hcount==h_total-1 and vcount==v_total-1 while pending.
  - The next cycle shows hcount=0, vcount=0 with strobes computed from the new set.
  - `cfg_pending` clears on that same edge.
- A `cfg_load` in the apply cycle itself is not applied in that wrap. It is accepted into the shadow and waits for the next frame boundary.

## Timing
- Reset values:
  - hcount=0, vcount=0.
  - hblnk=0, vblnk=0.
  - hsync=!HSYNC_POL, vsync=!VSYNC_POL.
  - cfg_pending=0, cfg_err=0.
  - frame_start is combinational from the counters and `en`, so it equals `en` during reset.
- Reset mid-frame:
  - Immediately returns to the reset values.
  - Any pending shadow set is discarded.
- Frame period: h_total*v_total `en` cycles (720p: 1,237,500).
- `cfg_err` latency: asserted one cycle after the `cfg_load` edge.
- With `en` low for N cycles, every output holds for those N cycles.
- A pending apply waits until `en` is high in the final pixel of the frame.

## Test plan
- Reset, then defaults:
  - hblnk rises at hcount=1280 and falls at wrap (1649→0).
  - hsync is high for hcount 1390..1429.
  - vsync is high for vcount 725..729.
  - frame_start period is 1,237,500 cycles.
- Load h=(10,6,4,7,2), v=(5,3,2,3,1), pol=(0,0) mid-frame:
  - `cfg_pending`=1 until the frame wrap.
  - Next frame is 50 cycles long.
  - hsync is low for hcount 7..8.
  - vsync is low for vcount 3.
- Invalid load (h_sync_start=9, sync_time=2 with the small set above):
  - cfg_err=1 for one cycle.
  - cfg_pending and the active timing are unchanged.
- Two valid loads before the boundary: only the second is applied.
- A load in the apply cycle: the current pending set applies; the new set applies one frame later.
- `en` toggled low for 3 cycles at hcount=5, and `rst_n` pulsed mid-frame with a load pending:
  - While `en` is low, outputs hold.
  - After the reset pulse, counters are 0 and cfg_pending=0.
